// File: rtl/voice_scheduler.sv
// Polyphonic voice scheduler: allocates note events to voices and, once per sample
// period, walks every voice through a shared step table and a shared sine table.
module voice_scheduler #(
  parameter int VOICES = 4,
  parameter int N      = 24,
  parameter int M      = 12
) (
  input  logic              inCLK_50MHZ,
  input  logic              inRESET,
  input  logic              inSAMPLE_CLK,
  input  logic [1:0]        inWaveMode,
  input  logic              inNoteValid,
  input  logic              inNoteOn,
  input  logic [6:0]        inNoteIndex,
  output logic              outNoteAck,
  output logic [6:0]        outFreqIdx,
  input  logic [N-1:0]      inFreqStep,
  output logic [9:0]        outPhaseIdx,
  input  logic [M-1:0]      inSineSample,
  output logic [M-1:0]      outSample,
  output logic              outSampleReady,
  output logic [VOICES-1:0] outVoiceActive,
  output logic              outBusy,
  output logic [2:0]        dbg_state
);
  localparam int LOGV = $clog2(VOICES);
  localparam int AW   = M + LOGV;
  localparam logic [M-1:0] SQ_POS = {1'b0, {(M-1){1'b1}}};
  localparam logic [M-1:0] SQ_NEG = {1'b1, {(M-2){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NOTE  = 3'd1,
    S_FETCH = 3'd2,
    S_ACCUM = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  // Handshake: inNoteValid is held by the requester until outNoteAck; the
  // event is consumed in the single cycle outNoteAck is high.
  state_t            state_q, state_d;
  logic [LOGV-1:0]   v_q, v_d, v_next;
  logic [AW-1:0]     acc_q, acc_d, acc_next;
  logic              samp_q, samp_d;
  logic [VOICES-1:0] active_q, active_d;
  logic [6:0]        note_q [VOICES];
  logic [6:0]        note_d [VOICES];
  logic [N-1:0]      phase_q [VOICES];
  logic [N-1:0]      phase_d [VOICES];
  logic [LOGV-1:0]   ptr_q, ptr_d;
  logic [6:0]        freq_idx_q, freq_idx_d;
  logic [9:0]        phase_idx_q, phase_idx_d;
  logic [M-1:0]      sample_q, sample_d;
  logic              ready_q, ready_d;
  logic              ack_q, ack_d;
  logic [M-1:0]      wave;
  logic              found;
  logic              samp_edge;

  assign samp_edge = inSAMPLE_CLK & ~samp_q;

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    v_next      = v_q + 1'b1;
    acc_d       = acc_q;
    acc_next    = acc_q;
    samp_d      = inSAMPLE_CLK;
    active_d    = active_q;
    note_d      = note_q;
    phase_d     = phase_q;
    ptr_d       = ptr_q;
    freq_idx_d  = freq_idx_q;
    phase_idx_d = phase_idx_q;
    sample_d    = sample_q;
    ready_d     = 1'b0;
    ack_d       = 1'b0;
    wave        = '0;
    found       = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A sample edge wins over a pending note; the note waits for the frame.
        if (samp_edge) begin
          state_d     = S_FETCH;
          v_d         = '0;
          acc_d       = '0;
          freq_idx_d  = note_q[0];
          phase_idx_d = phase_q[0][N-1 -: 10];
        end else if (inNoteValid) begin
          state_d = S_NOTE;
          ack_d   = 1'b1;
        end
      end
      S_NOTE: begin
        state_d = S_IDLE;
        if (inNoteOn) begin
          for (int i = 0; i < VOICES; i++) begin
            if (!found && active_q[i] && note_q[i] == inNoteIndex) begin
              found      = 1'b1;
              phase_d[i] = '0;
            end
          end
          for (int i = 0; i < VOICES; i++) begin
            if (!found && !active_q[i]) begin
              found       = 1'b1;
              active_d[i] = 1'b1;
              note_d[i]   = inNoteIndex;
              phase_d[i]  = '0;
            end
          end
          if (!found) begin
            note_d[ptr_q]  = inNoteIndex;
            phase_d[ptr_q] = '0;
            ptr_d          = ptr_q + 1'b1;
          end
        end else begin
          for (int i = 0; i < VOICES; i++) begin
            if (active_q[i] && note_q[i] == inNoteIndex) active_d[i] = 1'b0;
          end
        end
      end
      S_FETCH: begin
        state_d = S_ACCUM;
      end
      S_ACCUM: begin
        if (active_q[v_q]) begin
          phase_d[v_q] = phase_q[v_q] + inFreqStep;
          if (inWaveMode == 2'd1) wave = phase_q[v_q][N-1] ? SQ_NEG : SQ_POS;
          else                    wave = inSineSample;
          acc_next = acc_q + {{LOGV{wave[M-1]}}, wave};
        end
        acc_d = acc_next;
        if (v_q == LOGV'(VOICES - 1)) begin
          state_d  = S_OUT;
          ready_d  = 1'b1;
          sample_d = acc_next[AW-1:LOGV];
        end else begin
          state_d     = S_FETCH;
          v_d         = v_next;
          freq_idx_d  = note_q[v_next];
          phase_idx_d = phase_q[v_next][N-1 -: 10];
        end
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge inCLK_50MHZ) begin
    if (inRESET) begin
      state_q     <= S_IDLE;
      v_q         <= '0;
      acc_q       <= '0;
      samp_q      <= 1'b1;
      active_q    <= '0;
      ptr_q       <= '0;
      freq_idx_q  <= '0;
      phase_idx_q <= '0;
      sample_q    <= '0;
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        note_q[i]  <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      acc_q       <= acc_d;
      samp_q      <= samp_d;
      active_q    <= active_d;
      ptr_q       <= ptr_d;
      freq_idx_q  <= freq_idx_d;
      phase_idx_q <= phase_idx_d;
      sample_q    <= sample_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      note_q      <= note_d;
      phase_q     <= phase_d;
    end
  end

  assign outNoteAck     = ack_q;
  assign outFreqIdx     = freq_idx_q;
  assign outPhaseIdx    = phase_idx_q;
  assign outSample      = sample_q;
  assign outSampleReady = ready_q;
  assign outVoiceActive = active_q;
  assign outBusy        = (state_q != S_IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Bench for voice_scheduler: behavioural voice model feeds an expected-sample
// queue; a negedge monitor pops and compares on every outSampleReady strobe.
module tb_voice_scheduler;
  localparam int V = 4;
  localparam int N = 24;
  localparam int M = 12;

  logic          clk;
  logic          inRESET;
  logic          inSAMPLE_CLK;
  logic [1:0]    inWaveMode;
  logic          inNoteValid;
  logic          inNoteOn;
  logic [6:0]    inNoteIndex;
  logic          outNoteAck;
  logic [6:0]    outFreqIdx;
  logic [N-1:0]  inFreqStep;
  logic [9:0]    outPhaseIdx;
  logic [M-1:0]  inSineSample;
  logic [M-1:0]  outSample;
  logic          outSampleReady;
  logic [V-1:0]  outVoiceActive;
  logic          outBusy;
  logic [2:0]    dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [M-1:0] exp_q[$];

  // Voice model
  logic [V-1:0] m_active;
  logic [6:0]   m_note  [V];
  logic [N-1:0] m_phase [V];
  int           m_ptr;

  voice_scheduler #(.VOICES(V), .N(N), .M(M)) dut (
    .inCLK_50MHZ   (clk),
    .inRESET       (inRESET),
    .inSAMPLE_CLK  (inSAMPLE_CLK),
    .inWaveMode    (inWaveMode),
    .inNoteValid   (inNoteValid),
    .inNoteOn      (inNoteOn),
    .inNoteIndex   (inNoteIndex),
    .outNoteAck    (outNoteAck),
    .outFreqIdx    (outFreqIdx),
    .inFreqStep    (inFreqStep),
    .outPhaseIdx   (outPhaseIdx),
    .inSineSample  (inSineSample),
    .outSample     (outSample),
    .outSampleReady(outSampleReady),
    .outVoiceActive(outVoiceActive),
    .outBusy       (outBusy),
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Shared lookup tables, owned by the bench
  function automatic logic [N-1:0] step_of(input logic [6:0] idx);
    int n;
    n = int'(idx);
    if (n >= 100) return 24'h800000;
    return N'(n * 20000 + 12345);
  endfunction

  function automatic int sine_val(input logic [9:0] p);
    return ((int'(p) * 13) % 4000) - 2000;
  endfunction

  assign inFreqStep   = step_of(outFreqIdx);
  assign inSineSample = M'(sine_val(outPhaseIdx));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard
  always @(negedge clk) begin
    if (outSampleReady === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_strobe", 32'd1, 32'd0);
      else                   check("sample", 32'(outSample), 32'(exp_q.pop_front()));
    end
  end

  task automatic model_reset();
    m_active = '0;
    m_ptr    = 0;
    for (int i = 0; i < V; i++) begin
      m_note[i]  = '0;
      m_phase[i] = '0;
    end
  endtask

  task automatic model_note(input bit on, input logic [6:0] idx);
    bit done;
    done = 1'b0;
    if (on) begin
      for (int i = 0; i < V; i++)
        if (!done && m_active[i] && m_note[i] == idx) begin
          done = 1'b1; m_phase[i] = '0;
        end
      for (int i = 0; i < V; i++)
        if (!done && !m_active[i]) begin
          done = 1'b1; m_active[i] = 1'b1; m_note[i] = idx; m_phase[i] = '0;
        end
      if (!done) begin
        m_note[m_ptr]  = idx;
        m_phase[m_ptr] = '0;
        m_ptr          = (m_ptr + 1) % V;
      end
    end else begin
      for (int i = 0; i < V; i++)
        if (m_active[i] && m_note[i] == idx) m_active[i] = 1'b0;
    end
  endtask

  task automatic model_frame(input logic [1:0] mode, output logic [M-1:0] e);
    int acc;
    acc = 0;
    for (int i = 0; i < V; i++) begin
      if (m_active[i]) begin
        if (mode == 2'd1) acc += m_phase[i][N-1] ? -2047 : 2047;
        else              acc += sine_val(m_phase[i][N-1:N-10]);
        m_phase[i] = m_phase[i] + step_of(m_note[i]);
      end
    end
    e = M'(acc >>> 2);
  endtask

  // Driver tasks
  task automatic do_reset();
    @(negedge clk);
    inRESET      = 1'b1;
    inSAMPLE_CLK = 1'b1;
    inNoteValid  = 1'b0;
    repeat (2) @(negedge clk);
    inRESET = 1'b0;
    model_reset();
  endtask

  task automatic do_note(input bit on, input logic [6:0] idx);
    int  cnt;
    bit  got;
    @(negedge clk);
    inNoteValid = 1'b1;
    inNoteOn    = on;
    inNoteIndex = idx;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (outNoteAck) got = 1'b1;
    end
    check("note_ack", 32'(got), 32'd1);
    inNoteValid = 1'b0;
    model_note(on, idx);
    @(negedge clk);
    check("ack_once", 32'(outNoteAck), 32'd0);
    check("voice_active", 32'(outVoiceActive), 32'(m_active));
  endtask

  task automatic do_frame(input logic [1:0] mode);
    logic [M-1:0] e;
    int cnt;
    bit got;
    model_frame(mode, e);
    exp_q.push_back(e);
    @(negedge clk);
    inSAMPLE_CLK = 1'b0;
    @(negedge clk);
    inWaveMode   = mode;
    inSAMPLE_CLK = 1'b1;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (outSampleReady) got = 1'b1;
    end
    check("ready_latency", 32'(cnt), 32'(2 * V + 1));
    inSAMPLE_CLK = 1'b0;
    @(negedge clk);
    check("sample_hold", 32'(outSample), 32'(e));
  endtask

  initial begin
    int cnt, rdy, ack;
    logic [M-1:0] e;
    inRESET      = 1'b0;
    inSAMPLE_CLK = 1'b1;
    inWaveMode   = 2'd0;
    inNoteValid  = 1'b0;
    inNoteOn     = 1'b0;
    inNoteIndex  = '0;
    model_reset();

    // 1: reset with the sample clock held high
    do_reset();
    check("rst_sample", 32'(outSample), 32'd0);
    check("rst_ready", 32'(outSampleReady), 32'd0);
    check("rst_ack", 32'(outNoteAck), 32'd0);
    check("rst_active", 32'(outVoiceActive), 32'd0);
    check("rst_busy", 32'(outBusy), 32'd0);
    check("rst_idx", 32'({outFreqIdx, outPhaseIdx}), 32'd0);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (outSampleReady || outBusy) cnt++;
    end
    check("no_frame_while_high", 32'(cnt), 32'd0);

    // 2: single sine voice over several frames
    do_note(1'b1, 7'd69);
    repeat (3) do_frame(2'd0);

    // 3: allocation and stealing
    do_reset();
    for (int n = 60; n <= 64; n++) do_note(1'b1, 7'(n));
    do_frame(2'd0);
    do_note(1'b1, 7'd65);
    do_frame(2'd0);

    // 4: retrigger and note-off
    do_reset();
    do_note(1'b1, 7'd60);
    do_frame(2'd0);
    do_frame(2'd0);
    do_note(1'b1, 7'd60);
    do_frame(2'd0);
    do_note(1'b0, 7'd60);
    do_frame(2'd0);
    do_note(1'b0, 7'd70);

    // 5: square extremes, plus modes 2/3 as sine
    do_reset();
    for (int n = 100; n <= 103; n++) do_note(1'b1, 7'(n));
    do_frame(2'd1);
    do_frame(2'd1);
    do_frame(2'd1);
    do_frame(2'd2);
    do_frame(2'd3);

    // Random mix of events and frames
    do_reset();
    for (int k = 0; k < 10; k++) begin
      do_note(($urandom_range(0, 3) != 0), 7'($urandom_range(58, 63)));
      do_frame(2'($urandom_range(0, 3)));
    end

    // 6a: note request in the same cycle as the sample edge
    model_frame(2'd0, e);
    exp_q.push_back(e);
    @(negedge clk);
    inWaveMode   = 2'd0;
    inSAMPLE_CLK = 1'b1;
    inNoteValid  = 1'b1;
    inNoteOn     = 1'b1;
    inNoteIndex  = 7'd72;
    cnt = 0;
    rdy = -1;
    ack = -1;
    while (cnt < 40 && ack < 0) begin
      @(negedge clk);
      cnt++;
      if (outSampleReady && rdy < 0) rdy = cnt;
      if (outNoteAck) ack = cnt;
    end
    inNoteValid  = 1'b0;
    inSAMPLE_CLK = 1'b0;
    model_note(1'b1, 7'd72);
    check("prio_ready_cycle", 32'(rdy), 32'(2 * V + 1));
    check("prio_ack_after_frame", 32'(ack > rdy), 32'd1);
    check("prio_ack_bound", 32'(ack <= 2 * V + 3), 32'd1);
    @(negedge clk);
    check("prio_active", 32'(outVoiceActive), 32'(m_active));

    // 6b: reset during ACCUM of voice 1
    @(negedge clk);
    inSAMPLE_CLK = 1'b1;
    repeat (4) @(negedge clk);
    check("busy_mid_frame", 32'(outBusy), 32'd1);
    check("state_accum", 32'(dbg_state), 32'd3);
    inRESET = 1'b1;
    @(negedge clk);
    inRESET = 1'b0;
    model_reset();
    check("midrst_active", 32'(outVoiceActive), 32'd0);
    check("midrst_busy", 32'(outBusy), 32'd0);
    check("midrst_state", 32'(dbg_state), 32'd0);
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (outSampleReady || outNoteAck) cnt++;
    end
    check("midrst_no_strobe", 32'(cnt), 32'd0);
    inSAMPLE_CLK = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
